shift_sequencer: RTL and testbench

Multi-cycle shift unit controller for the MIPS datapath. It selects the 5-bit shift amount from register B, the instruction shamt field or the extended offset, using the same 0/1/2 encoding as the shift-amount mux. It then shifts a 32-bit operand iteratively, one position per cycle, and reports completion to the main control FSM with a one-cycle `done` pulse. The main control FSM holds its state until `done` is seen, then writes `result` back.

---
 rtl/shift_sequencer.sv | 161 ++++++++++++++++
 tb/tb_shift_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle shift unit controller for the MIPS datapath.
// Selects a 5-bit shift amount, shifts a 32-bit operand iteratively and
// signals completion with a one-cycle done pulse.
// Optional build macro: SHIFT_SEQ_FAST_EN enables 4-position steps while
// the remaining count is at least 4.
module shift_sequencer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  shift_type,
    input  logic [1:0]  amt_src,
    input  logic [4:0]  reg_b_amt,
    input  logic [4:0]  shamt,
    input  logic [4:0]  ext_off_amt,
    input  logic [31:0] data_in,
    output logic [1:0]  amt_sel,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] TYPE_SLL = 2'b00;
    localparam logic [1:0] TYPE_SRL = 2'b01;
    localparam logic [1:0] TYPE_SRA = 2'b10;
    localparam logic [1:0] TYPE_ROR = 2'b11;

    state_t      state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic [31:0] result_q, result_d;
    logic [1:0]  type_q, type_d;
    logic [1:0]  amt_sel_q, amt_sel_d;
    logic        err_q, err_d;

    logic [4:0]  sel_amt;
    logic [4:0]  step_size;
    logic [31:0] step_result;

    // Single-position step; fill depends on the latched shift type.
    function automatic logic [31:0] shift_by_one(input logic [31:0] v, input logic [1:0] t);
        logic [31:0] r;
        case (t)
            TYPE_SLL: r = {v[30:0], 1'b0};
            TYPE_SRL: r = {1'b0, v[31:1]};
            TYPE_SRA: r = {v[31], v[31:1]};
            TYPE_ROR: r = {v[0], v[31:1]};
            default:  r = v;
        endcase
        return r;
    endfunction

`ifdef SHIFT_SEQ_FAST_EN
    // Four-position step with the same fill rules as the single step.
    function automatic logic [31:0] shift_by_four(input logic [31:0] v, input logic [1:0] t);
        logic [31:0] r;
        case (t)
            TYPE_SLL: r = {v[27:0], 4'b0000};
            TYPE_SRL: r = {4'b0000, v[31:4]};
            TYPE_SRA: r = {{4{v[31]}}, v[31:4]};
            TYPE_ROR: r = {v[3:0], v[31:4]};
            default:  r = v;
        endcase
        return r;
    endfunction
`endif

    // Shift-amount mux using the datapath's 0/1/2 source encoding.
    always_comb begin
        sel_amt = 5'd0;
        case (amt_src)
            2'd0:    sel_amt = reg_b_amt;
            2'd1:    sel_amt = shamt;
            2'd2:    sel_amt = ext_off_amt;
            default: sel_amt = 5'd0;
        endcase
    end

    // One SHIFT-state step: size of the step and the resulting operand.
    always_comb begin
        step_size   = 5'd1;
        step_result = shift_by_one(result_q, type_q);
`ifdef SHIFT_SEQ_FAST_EN
        if (count_q >= 5'd4) begin
            step_size   = 5'd4;
            step_result = shift_by_four(result_q, type_q);
        end
`endif
    end

    // Next-state and datapath-register updates for the IDLE/SHIFT/DONE sequence.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        result_d  = result_q;
        type_d    = type_q;
        amt_sel_d = amt_sel_q;
        err_d     = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (amt_src == 2'd3) begin
                        err_d     = 1'b1;
                        amt_sel_d = 2'd3;
                    end else begin
                        result_d  = data_in;
                        type_d    = shift_type;
                        amt_sel_d = amt_src;
                        count_d   = sel_amt;
                        err_d     = 1'b0;
                        state_d   = (sel_amt == 5'd0) ? ST_DONE : ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                result_d = step_result;
                count_d  = count_q - step_size;
                if (count_d == 5'd0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            count_q   <= 5'd0;
            result_q  <= 32'd0;
            type_q    <= TYPE_SLL;
            amt_sel_q <= 2'd0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            result_q  <= result_d;
            type_q    <= type_d;
            amt_sel_q <= amt_sel_d;
            err_q     <= err_d;
        end
    end

    assign busy    = (state_q == ST_SHIFT) || (state_q == ST_DONE);
    assign done    = (state_q == ST_DONE);
    assign result  = result_q;
    assign amt_sel = amt_sel_q;
    assign err     = err_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer.
module tb_shift_sequencer;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [1:0]  shift_type;
    logic [1:0]  amt_src;
    logic [4:0]  reg_b_amt;
    logic [4:0]  shamt;
    logic [4:0]  ext_off_amt;
    logic [31:0] data_in;
    logic [1:0]  amt_sel;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        err;

    int pass_cnt  = 0;
    int check_cnt = 0;
    int cyc;
    int extra_done;

    shift_sequencer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .shift_type  (shift_type),
        .amt_src     (amt_src),
        .reg_b_amt   (reg_b_amt),
        .shamt       (shamt),
        .ext_off_amt (ext_off_amt),
        .data_in     (data_in),
        .amt_sel     (amt_sel),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .err         (err)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected cycle (counted from the accepting edge) in which done is seen.
    function automatic int done_cycle(input int n);
`ifdef SHIFT_SEQ_FAST_EN
        return (n / 4) + (n % 4) + 1;
`else
        return n + 1;
`endif
    endfunction

    // Advance one clock and sample 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One comparison: counts it and reports any difference.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Present a start request; the call returns in the first cycle after the accepting edge.
    task automatic applyStimulus(input logic [1:0] typ, input logic [1:0] src,
                                 input logic [4:0] rb, input logic [4:0] sh,
                                 input logic [4:0] ext, input logic [31:0] data);
        shift_type  = typ;
        amt_src     = src;
        reg_b_amt   = rb;
        shamt       = sh;
        ext_off_amt = ext;
        data_in     = data;
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    // Wait (bounded) for done; cyc is the cycle index after the accepting edge.
    task automatic waitDone(output int c);
        c = 1;
        while (done !== 1'b1 && c < 64) begin
            tick();
            c++;
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        start       = 1'b0;
        shift_type  = 2'b00;
        amt_src     = 2'd0;
        reg_b_amt   = 5'd0;
        shamt       = 5'd0;
        ext_off_amt = 5'd0;
        data_in     = 32'd0;
        tick();
        tick();

        // Reset state
        checkOutput("rst_amt_sel", {30'd0, amt_sel}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_result", result, 32'd0);
        checkOutput("rst_err", {31'd0, err}, 32'd0);
        reset_n = 1'b1;
        tick();

        // Reset in the middle of SLL by 10
        applyStimulus(2'b00, 2'd0, 5'd10, 5'd0, 5'd0, 32'h0000_0001);
        tick();
        tick();
        checkOutput("mid_busy", {31'd0, busy}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("mid_rst_done", {31'd0, done}, 32'd0);
        checkOutput("mid_rst_result", result, 32'd0);
        checkOutput("mid_rst_amt_sel", {30'd0, amt_sel}, 32'd0);
        checkOutput("mid_rst_err", {31'd0, err}, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        applyStimulus(2'b00, 2'd0, 5'd1, 5'd0, 5'd0, 32'h0000_0001);
        waitDone(cyc);
        checkOutput("sll1_cycle", cyc, done_cycle(1));
        checkOutput("sll1_result", result, 32'h0000_0002);
        tick();

        // SLL by shamt=4
        applyStimulus(2'b00, 2'd1, 5'd0, 5'd4, 5'd0, 32'h0000_000F);
        checkOutput("sll4_amt_sel", {30'd0, amt_sel}, 32'd1);
        waitDone(cyc);
        checkOutput("sll4_cycle", cyc, done_cycle(4));
        checkOutput("sll4_result", result, 32'h0000_00F0);
        checkOutput("sll4_busy", {31'd0, busy}, 32'd1);
        tick();
        checkOutput("sll4_done_fall", {31'd0, done}, 32'd0);
        checkOutput("sll4_busy_fall", {31'd0, busy}, 32'd0);
        checkOutput("sll4_hold", result, 32'h0000_00F0);

        // SRA and SRL by 31 from register B
        applyStimulus(2'b10, 2'd0, 5'd31, 5'd0, 5'd0, 32'h8000_0000);
        waitDone(cyc);
        checkOutput("sra31_cycle", cyc, done_cycle(31));
        checkOutput("sra31_result", result, 32'hFFFF_FFFF);
        tick();
        applyStimulus(2'b01, 2'd0, 5'd31, 5'd0, 5'd0, 32'h8000_0000);
        waitDone(cyc);
        checkOutput("srl31_cycle", cyc, done_cycle(31));
        checkOutput("srl31_result", result, 32'h0000_0001);
        tick();

        // ROR by ext_off_amt=8 with start held high throughout the shift
        applyStimulus(2'b11, 2'd2, 5'd0, 5'd0, 5'd8, 32'h1234_5678);
        start       = 1'b1;
        amt_src     = 2'd1;
        shamt       = 5'd0;
        data_in     = 32'hFFFF_0000;
        shift_type  = 2'b00;
        waitDone(cyc);
        start       = 1'b0;
        checkOutput("ror8_cycle", cyc, done_cycle(8));
        checkOutput("ror8_result", result, 32'h7812_3456);
        checkOutput("ror8_amt_sel", {30'd0, amt_sel}, 32'd2);
        extra_done = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done === 1'b1) extra_done++;
        end
        checkOutput("ror8_single_done", extra_done, 32'd0);
        checkOutput("ror8_hold", result, 32'h7812_3456);

        // Amount 0 completes right after the accepting edge
        applyStimulus(2'b10, 2'd1, 5'd7, 5'd0, 5'd3, 32'hA5A5_0F0F);
        checkOutput("zero_done", {31'd0, done}, 32'd1);
        checkOutput("zero_busy", {31'd0, busy}, 32'd1);
        checkOutput("zero_result", result, 32'hA5A5_0F0F);
        tick();
        checkOutput("zero_busy_fall", {31'd0, busy}, 32'd0);
        checkOutput("zero_done_fall", {31'd0, done}, 32'd0);

        // Illegal amount source
        applyStimulus(2'b00, 2'd3, 5'd2, 5'd2, 5'd2, 32'hDEAD_BEEF);
        checkOutput("ill_err", {31'd0, err}, 32'd1);
        checkOutput("ill_amt_sel", {30'd0, amt_sel}, 32'd3);
        checkOutput("ill_busy", {31'd0, busy}, 32'd0);
        checkOutput("ill_result", result, 32'hA5A5_0F0F);
        extra_done = 0;
        for (int i = 0; i < 4; i++) begin
            if (done === 1'b1) extra_done++;
            tick();
        end
        checkOutput("ill_no_done", extra_done, 32'd0);
        checkOutput("ill_err_sticky", {31'd0, err}, 32'd1);
        applyStimulus(2'b01, 2'd0, 5'd1, 5'd0, 5'd0, 32'h0000_0008);
        checkOutput("legal_err_clear", {31'd0, err}, 32'd0);
        checkOutput("legal_amt_sel", {30'd0, amt_sel}, 32'd0);
        waitDone(cyc);
        checkOutput("legal_cycle", cyc, done_cycle(1));
        checkOutput("legal_result", result, 32'h0000_0004);
        tick();

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
